bus_arbiter: RTL and testbench

Shares the single external memory port between the instruction-fetch bus (ibus) and the MemAccess data bus (dbus). It sequences one transaction at a time over a request/acknowledge handshake and returns the per-requester read data. It produces the stall requests that freeze the pipeline while an access is outstanding. It sits between the core pipeline and the memory/bridge interface.

---
 rtl/bus_arbiter_pkg.sv | 17 +
 rtl/bus_arbiter.sv | 122 ++++++++++++
 tb/tb_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared widths, constants and FSM state encodings for the memory-port arbiter.
package bus_arbiter_pkg;

    localparam int AddrBus = 32;
    localparam int DataBus = 32;
    localparam int ByteWEn = 4;

    localparam logic [DataBus-1:0] ZeroWord  = '0;
    localparam logic [ByteWEn-1:0] WrDisable = '0;

    typedef enum logic [1:0] {
        BA_IDLE  = 2'd0,
        BA_GNT_I = 2'd1,
        BA_GNT_D = 2'd2
    } ba_state_e;

endpackage

// File: rtl/bus_arbiter.sv
// Arbitrates ibus/dbus onto one memory port; BUS_ARB_ROUND_ROBIN_EN selects round-robin in IDLE.
// Latency: grant one cycle after a request is seen in IDLE, completion on mem_ack (minimum 2 cycles).
// Backpressure: each requester is stalled until its mem_ack; a completion can hand off back-to-back.
module bus_arbiter
    import bus_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ibus_en,
    input  logic [AddrBus-1:0] ibus_addr,
    output logic [DataBus-1:0] ibus_rdata,
    output logic               ibus_stallreq,
    input  logic               dbus_en,
    input  logic [AddrBus-1:0] dbus_addr,
    input  logic [ByteWEn-1:0] dbus_wen,
    input  logic [DataBus-1:0] dbus_wdata,
    output logic [DataBus-1:0] dbus_rdata,
    output logic               dbus_stallreq,
    output logic               mem_en,
    output logic [AddrBus-1:0] mem_addr,
    output logic [ByteWEn-1:0] mem_wen,
    output logic [DataBus-1:0] mem_wdata,
    input  logic [DataBus-1:0] mem_rdata,
    input  logic               mem_ack
);

    ba_state_e          state, state_nxt;
    logic               gnt_i, gnt_d;
    logic [DataBus-1:0] ibus_rdata_q, dbus_rdata_q;
    ba_state_e          both_pick;

    assign gnt_i = (state == BA_GNT_I);
    assign gnt_d = (state == BA_GNT_D);

`ifdef BUS_ARB_ROUND_ROBIN_EN
    // 1 = dbus was served last; reset value points at ibus
    logic last_dbus;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dbus <= 1'b0;
        end else if (mem_ack && (gnt_i || gnt_d)) begin
            last_dbus <= gnt_d;
        end
    end

    assign both_pick = last_dbus ? BA_GNT_I : BA_GNT_D;
`else
    assign both_pick = BA_GNT_D;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BA_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BA_IDLE: begin
                if (ibus_en && dbus_en) begin
                    state_nxt = both_pick;
                end else if (dbus_en) begin
                    state_nxt = BA_GNT_D;
                end else if (ibus_en) begin
                    state_nxt = BA_GNT_I;
                end
            end
            BA_GNT_I: begin
                if (mem_ack) begin
                    state_nxt = dbus_en ? BA_GNT_D : BA_IDLE;
                end
            end
            BA_GNT_D: begin
                if (mem_ack) begin
                    state_nxt = ibus_en ? BA_GNT_I : BA_IDLE;
                end
            end
            default: state_nxt = BA_IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_addr  = ZeroWord;
        mem_wen   = WrDisable;
        mem_wdata = ZeroWord;
        if (gnt_i) begin
            mem_en   = 1'b1;
            mem_addr = ibus_addr;
        end else if (gnt_d) begin
            mem_en    = 1'b1;
            mem_addr  = dbus_addr;
            mem_wen   = dbus_wen;
            mem_wdata = dbus_wdata;
        end
    end

    // Stores return no data, so only read completions refresh the dbus holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ibus_rdata_q <= ZeroWord;
            dbus_rdata_q <= ZeroWord;
        end else begin
            if (gnt_i && mem_ack) begin
                ibus_rdata_q <= mem_rdata;
            end
            if (gnt_d && mem_ack && (dbus_wen == WrDisable)) begin
                dbus_rdata_q <= mem_rdata;
            end
        end
    end

    assign ibus_rdata    = gnt_i ? mem_rdata : ibus_rdata_q;
    assign dbus_rdata    = gnt_d ? mem_rdata : dbus_rdata_q;
    assign ibus_stallreq = ibus_en & ~(gnt_i & mem_ack);
    assign dbus_stallreq = dbus_en & ~(gnt_d & mem_ack);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter; inputs change and outputs are sampled around the falling edge.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_en;
    logic [31:0] ibus_addr;
    logic [31:0] ibus_rdata;
    logic        ibus_stallreq;
    logic        dbus_en;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_wen;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_stallreq;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .ibus_en       (ibus_en),
        .ibus_addr     (ibus_addr),
        .ibus_rdata    (ibus_rdata),
        .ibus_stallreq (ibus_stallreq),
        .dbus_en       (dbus_en),
        .dbus_addr     (dbus_addr),
        .dbus_wen      (dbus_wen),
        .dbus_wdata    (dbus_wdata),
        .dbus_rdata    (dbus_rdata),
        .dbus_stallreq (dbus_stallreq),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack)
    );

    task automatic test_reset();
        @(negedge clk); #1;
        vectors++;
        if ({mem_en, mem_addr, mem_wen, mem_wdata} !== 69'd0) begin
            miscompares++;
            $display("FAIL reset_mem got en=%b addr=%h wen=%h wdata=%h exp all 0", mem_en, mem_addr, mem_wen, mem_wdata);
        end
        vectors++;
        if ({ibus_rdata, dbus_rdata, ibus_stallreq, dbus_stallreq} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_bus got irdata=%h drdata=%h istall=%b dstall=%b exp all 0", ibus_rdata, dbus_rdata, ibus_stallreq, dbus_stallreq);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        ibus_en = 1'b1; ibus_addr = 32'hBFC0_0000; #1;
        vectors++;
        if ({mem_en, ibus_stallreq} !== 2'b01) begin
            miscompares++;
            $display("FAIL fetch_c0 got mem_en=%b stall=%b exp 0 1", mem_en, ibus_stallreq);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); #1;
            vectors++;
            if ({mem_en, ibus_stallreq, mem_addr, mem_wen} !== {2'b11, 32'hBFC0_0000, 4'h0}) begin
                miscompares++;
                $display("FAIL fetch_c%0d got en=%b stall=%b addr=%h wen=%h exp 1 1 bfc00000 0", c, mem_en, ibus_stallreq, mem_addr, mem_wen);
            end
        end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h2402_0001; #1;
        vectors++;
        if ({ibus_stallreq, ibus_rdata} !== {1'b0, 32'h2402_0001}) begin
            miscompares++;
            $display("FAIL fetch_ack got stall=%b rdata=%h exp 0 24020001", ibus_stallreq, ibus_rdata);
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0; ibus_en = 1'b0; #1;
        vectors++;
        if ({mem_en, ibus_rdata} !== {1'b0, 32'h2402_0001}) begin
            miscompares++;
            $display("FAIL fetch_hold got en=%b rdata=%h exp 0 24020001", mem_en, ibus_rdata);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        ibus_en = 1'b1; ibus_addr = 32'h0000_1000;
        dbus_en = 1'b1; dbus_addr = 32'h0000_2000; dbus_wen = 4'hF; dbus_wdata = 32'hDEAD_BEEF; #1;
        @(negedge clk); #1;
        vectors++;
        if ({mem_en, mem_addr, mem_wen, mem_wdata} !== {1'b1, 32'h0000_2000, 4'hF, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL b2b_dgrant got en=%b addr=%h wen=%h wdata=%h exp 1 00002000 f deadbeef", mem_en, mem_addr, mem_wen, mem_wdata);
        end
        vectors++;
        if ({ibus_stallreq, dbus_stallreq} !== 2'b11) begin
            miscompares++;
            $display("FAIL b2b_stall got i=%b d=%b exp 1 1", ibus_stallreq, dbus_stallreq);
        end
        @(negedge clk);
        mem_ack = 1'b1; #1;
        vectors++;
        if ({ibus_stallreq, dbus_stallreq} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_dack got i=%b d=%b exp 1 0", ibus_stallreq, dbus_stallreq);
        end
        @(negedge clk);
        mem_ack = 1'b0; dbus_en = 1'b0; dbus_wen = 4'h0; #1;
        vectors++;
        if ({mem_en, mem_addr, mem_wen, mem_wdata} !== {1'b1, 32'h0000_1000, 4'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL b2b_igrant got en=%b addr=%h wen=%h wdata=%h exp 1 00001000 0 0", mem_en, mem_addr, mem_wen, mem_wdata);
        end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_0000; #1;
        @(negedge clk);
        mem_ack = 1'b0; ibus_en = 1'b0; #1;
        vectors++;
        if ({mem_en, ibus_rdata} !== {1'b0, 32'hA5A5_0000}) begin
            miscompares++;
            $display("FAIL b2b_done got en=%b irdata=%h exp 0 a5a50000", mem_en, ibus_rdata);
        end
    endtask

    task automatic test_byte_store();
        // Seed the dbus holding register with a read first
        @(negedge clk);
        dbus_en = 1'b1; dbus_addr = 32'h0000_0010; dbus_wen = 4'h0; #1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h1122_3344; #1;
        @(negedge clk);
        mem_ack = 1'b0; dbus_en = 1'b0; #1;
        vectors++;
        if (dbus_rdata !== 32'h1122_3344) begin
            miscompares++;
            $display("FAIL load_data got %h exp 11223344", dbus_rdata);
        end
        @(negedge clk);
        dbus_en = 1'b1; dbus_addr = 32'h8000_0001; dbus_wen = 4'b0010; dbus_wdata = 32'h0000_5A00; #1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            if (c == 2) begin
                mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
            end
            #1;
            vectors++;
            if ({mem_addr, mem_wen} !== {32'h8000_0001, 4'b0010}) begin
                miscompares++;
                $display("FAIL store_c%0d got addr=%h wen=%b exp 80000001 0010", c, mem_addr, mem_wen);
            end
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0; dbus_en = 1'b0; dbus_wen = 4'h0; #1;
        vectors++;
        if ({mem_en, dbus_rdata} !== {1'b0, 32'h1122_3344}) begin
            miscompares++;
            $display("FAIL store_rdata got en=%b drdata=%h exp 0 11223344", mem_en, dbus_rdata);
        end
    endtask

    // dbus was served last here, so round-robin hands the tie to ibus
    task automatic test_priority_after_dbus();
        logic [31:0] exp_addr;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        exp_addr = 32'h0000_3000;
`else
        exp_addr = 32'h0000_4000;
`endif
        @(negedge clk);
        ibus_en = 1'b1; ibus_addr = 32'h0000_3000;
        dbus_en = 1'b1; dbus_addr = 32'h0000_4000; dbus_wen = 4'h0; #1;
        @(negedge clk); #1;
        vectors++;
        if ({mem_en, mem_addr} !== {1'b1, exp_addr}) begin
            miscompares++;
            $display("FAIL tie_grant got en=%b addr=%h exp 1 %h", mem_en, mem_addr, exp_addr);
        end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0077; #1;
        @(negedge clk);
        mem_ack = 1'b0;
        if (exp_addr == 32'h0000_3000) ibus_en = 1'b0; else dbus_en = 1'b0;
        #1;
        vectors++;
        if ({mem_en, mem_addr} !== {1'b1, (exp_addr == 32'h0000_3000) ? 32'h0000_4000 : 32'h0000_3000}) begin
            miscompares++;
            $display("FAIL tie_second got en=%b addr=%h", mem_en, mem_addr);
        end
        @(negedge clk);
        mem_ack = 1'b1; #1;
        @(negedge clk);
        mem_ack = 1'b0; ibus_en = 1'b0; dbus_en = 1'b0; #1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        dbus_en = 1'b1; dbus_addr = 32'h0000_5000; dbus_wen = 4'h0; #1;
        @(negedge clk); #1;
        vectors++;
        if (mem_en !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pre got en=%b exp 1", mem_en);
        end
        rst = 1'b1; #1;
        vectors++;
        if ({mem_en, mem_addr} !== 33'd0) begin
            miscompares++;
            $display("FAIL rstmid_async got en=%b addr=%h exp 0 0", mem_en, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0; dbus_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_5555; #1;
        @(negedge clk);
        mem_ack = 1'b0; ibus_en = 1'b1; ibus_addr = 32'h0000_6000; #1;
        vectors++;
        if ({mem_en, dbus_rdata} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL rstmid_late_ack got en=%b drdata=%h exp 0 0", mem_en, dbus_rdata);
        end
        @(negedge clk); #1;
        vectors++;
        if ({mem_en, mem_addr} !== {1'b1, 32'h0000_6000}) begin
            miscompares++;
            $display("FAIL rstmid_regrant got en=%b addr=%h exp 1 00006000", mem_en, mem_addr);
        end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678; #1;
        @(negedge clk);
        mem_ack = 1'b0; ibus_en = 1'b0; #1;
    endtask

    task automatic test_stray_ack();
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0099; #1;
        vectors++;
        if ({mem_en, ibus_rdata, dbus_rdata} !== {1'b0, 32'h1234_5678, 32'h0}) begin
            miscompares++;
            $display("FAIL stray_during got en=%b irdata=%h drdata=%h exp 0 12345678 0", mem_en, ibus_rdata, dbus_rdata);
        end
        @(negedge clk);
        mem_ack = 1'b0; #1;
        vectors++;
        if ({mem_en, ibus_rdata, dbus_rdata} !== {1'b0, 32'h1234_5678, 32'h0}) begin
            miscompares++;
            $display("FAIL stray_after got en=%b irdata=%h drdata=%h exp 0 12345678 0", mem_en, ibus_rdata, dbus_rdata);
        end
    endtask

    initial begin
        rst = 1'b1;
        ibus_en = 1'b0; ibus_addr = 32'h0;
        dbus_en = 1'b0; dbus_addr = 32'h0; dbus_wen = 4'h0; dbus_wdata = 32'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_byte_store();
        test_priority_after_dbus();
        test_reset_mid();
        test_stray_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
